alu_mc: RTL and testbench

Parametrised multi-cycle execute-stage ALU for the MIPS-style pipeline, successor to the single-cycle combinational `alu`. It accepts one instruction per valid/ready handshake and computes arithmetic, logic and load/store effective-address results over a `WIDTH`-bit datapath. Multiplies run on an iterative shift-add unit, while all other ops complete in one cycle. Results are held in a registered output stage with back-pressure toward the MEM stage, plus zero, signed-overflow and illegal-opcode flags.

---
 rtl/alu_pkg.sv | 39 +++
 rtl/alu_mc_mul_iter.sv | 47 ++++
 rtl/alu_mc.sv | 129 ++++++++++++
 tb/tb_alu_mc.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared types and opcode helpers for the multi-cycle execute-stage ALU.
package alu_pkg;

    typedef enum logic [5:0] {
        OP_ADD  = 6'b000000,
        OP_ADDI = 6'b000001,
        OP_SUB  = 6'b000010,
        OP_SUBI = 6'b000011,
        OP_MUL  = 6'b000100,
        OP_MULI = 6'b000101,
        OP_OR   = 6'b000110,
        OP_ORI  = 6'b000111,
        OP_AND  = 6'b001000,
        OP_ANDI = 6'b001001,
        OP_XOR  = 6'b001010,
        OP_XORI = 6'b001011,
        OP_LDW  = 6'b001100,
        OP_STW  = 6'b001101
    } op_e;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MUL_BUSY = 2'd1,
        HOLD     = 2'd2
    } state_e;

    // Immediate forms take imm in place of rt. LDW/STW use imm only for the address.
    function automatic logic is_imm(input logic [5:0] op);
        case (op)
            OP_ADDI, OP_SUBI, OP_MULI, OP_ORI, OP_ANDI, OP_XORI: return 1'b1;
            default:                                             return 1'b0;
        endcase
    endfunction

    function automatic logic is_mul(input logic [5:0] op);
        return (op == OP_MUL) || (op == OP_MULI);
    endfunction

endpackage

// File: rtl/alu_mc_mul_iter.sv
// Radix-2 shift-add multiplier: low WIDTH bits of the unsigned product after WIDTH steps.
module mul_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] p
);
    localparam int CW = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] a_sh, b_sh, acc;
    logic [CW-1:0]    cnt;
    logic             busy;

    // Counter reaches WIDTH after the last step; done is high for that one cycle.
    assign done = busy && (cnt == CW'(WIDTH));
    assign p    = acc;

    // One partial product per cycle; start reloads, done retires the unit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh <= '0;
            b_sh <= '0;
            acc  <= '0;
            cnt  <= '0;
            busy <= 1'b0;
        end else if (start) begin
            a_sh <= a;
            b_sh <= b;
            acc  <= '0;
            cnt  <= '0;
            busy <= 1'b1;
        end else if (done) begin
            busy <= 1'b0;
        end else if (busy) begin
            if (b_sh[0]) acc <= acc + a_sh;
            a_sh <= a_sh << 1;
            b_sh <= b_sh >> 1;
            cnt  <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle execute ALU: single-cycle ops, iterative MUL, registered result with back-pressure.
module alu_mc
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [5:0]       op,
    input  logic [WIDTH-1:0] rs,
    input  logic [WIDTH-1:0] rt,
    input  logic [WIDTH-1:0] imm,
    input  logic [WIDTH-1:0] pc4_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] rd,
    output logic [WIDTH-1:0] addr,
    output logic [WIDTH-1:0] pc4_out,
    output logic             zero,
    output logic             ovf,
    output logic             illegal
);
    state_e           state, state_nx;
    logic             accept, mul_start, mul_done, load_alu, load_mul;
    logic [WIDTH-1:0] b_op, sum, diff, mul_p, pc4_pend;
    logic [WIDTH-1:0] alu_rd, alu_addr;
    logic             alu_ovf, alu_ill;

    assign in_ready  = (state == IDLE) || (state == HOLD && out_ready);
    assign out_valid = (state == HOLD);
    assign accept    = in_valid && in_ready;
    assign mul_start = accept && is_mul(op);
    assign load_alu  = accept && !is_mul(op);
    assign load_mul  = (state == MUL_BUSY) && mul_done;

    assign b_op = is_imm(op) ? imm : rt;
    assign sum  = rs + b_op;
    assign diff = rs - b_op;

    mul_iter #(.WIDTH(WIDTH)) u_mul (
        .clk   (clk),
        .rst_n (rst_n),
        .start (mul_start),
        .a     (rs),
        .b     (b_op),
        .done  (mul_done),
        .p     (mul_p)
    );

    // Single-cycle result and flags for every non-multiply opcode.
    always_comb begin
        alu_rd   = '0;
        alu_addr = '0;
        alu_ovf  = 1'b0;
        alu_ill  = 1'b0;
        case (op)
            OP_ADD, OP_ADDI: begin
                alu_rd  = sum;
                alu_ovf = (rs[WIDTH-1] == b_op[WIDTH-1]) && (sum[WIDTH-1] != rs[WIDTH-1]);
            end
            OP_SUB, OP_SUBI: begin
                alu_rd  = diff;
                alu_ovf = (rs[WIDTH-1] != b_op[WIDTH-1]) && (diff[WIDTH-1] != rs[WIDTH-1]);
            end
            OP_OR,  OP_ORI:  alu_rd = rs | b_op;
            OP_AND, OP_ANDI: alu_rd = rs & b_op;
            OP_XOR, OP_XORI: alu_rd = rs ^ b_op;
            OP_LDW, OP_STW: begin
                alu_rd   = rt;
                alu_addr = rs + imm;
            end
            OP_MUL, OP_MULI: ;
            default: alu_ill = 1'b1;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // Next state: HOLD and IDLE share the accept path so results can stream back-to-back.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE, HOLD: begin
                if (accept)                        state_nx = is_mul(op) ? MUL_BUSY : HOLD;
                else if (state == HOLD && !out_ready) state_nx = HOLD;
                else                               state_nx = IDLE;
            end
            MUL_BUSY: if (mul_done) state_nx = HOLD;
            default:  state_nx = IDLE;
        endcase
    end

    // Output registers load on a single-cycle accept or when the multiplier finishes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd       <= '0;
            addr     <= '0;
            pc4_out  <= '0;
            pc4_pend <= '0;
            zero     <= 1'b0;
            ovf      <= 1'b0;
            illegal  <= 1'b0;
        end else begin
            if (mul_start) pc4_pend <= pc4_in;
            if (load_alu) begin
                rd      <= alu_rd;
                addr    <= alu_addr;
                pc4_out <= pc4_in;
                zero    <= (alu_rd == '0);
                ovf     <= alu_ovf;
                illegal <= alu_ill;
            end else if (load_mul) begin
                rd      <= mul_p;
                addr    <= '0;
                pc4_out <= pc4_pend;
                zero    <= (mul_p == '0);
                ovf     <= 1'b0;
                illegal <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_alu_mc.sv
// Directed bench for alu_mc at WIDTH = 32: vector table plus multi-cycle sequences.
module tb_alu_mc;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0, out_ready = 1'b1;
    logic        in_ready, out_valid, zero, ovf, illegal;
    logic [5:0]  op = '0;
    logic [31:0] rs = '0, rt = '0, imm = '0, pc4_in = '0;
    logic [31:0] rd, addr, pc4_out;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    alu_mc #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .rs(rs), .rt(rt), .imm(imm), .pc4_in(pc4_in),
        .out_valid(out_valid), .out_ready(out_ready), .rd(rd), .addr(addr),
        .pc4_out(pc4_out), .zero(zero), .ovf(ovf), .illegal(illegal)
    );

    typedef struct {
        string       name;
        logic [5:0]  op;
        logic [31:0] rs, rt, imm;
        logic [31:0] e_rd, e_addr;
        logic        e_zero, e_ovf, e_ill;
    } vec_t;

    vec_t vecs[13];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic [5:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] im, input logic [31:0] pc);
        op = o; rs = a; rt = b; imm = im; pc4_in = pc; in_valid = 1'b1;
    endtask

    // MUL from accept to result; operands are scrambled after accept to prove capture.
    task automatic run_mul(input string nm, input logic [5:0] o, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] im, input logic [31:0] exp);
        int lat, rdy_bad;
        lat = 0; rdy_bad = 0;
        @(negedge clk);
        drive(o, a, b, im, 32'h0000_4440);
        @(posedge clk); #1;
        in_valid = 1'b0; rs = 32'h1357_9BDF; rt = 32'h2468_ACE0; imm = 32'h0F0F_0F0F; op = 6'b000000;
        while (!out_valid && lat < 40) begin
            if (in_ready) rdy_bad++;
            @(posedge clk); #1;
            lat++;
        end
        chk({nm, "_latency"}, 64'(lat), 64'd33);
        chk({nm, "_busy_ready_low"}, 64'(rdy_bad), 64'd0);
        chk({nm, "_rd"}, {32'd0, rd}, {32'd0, exp});
        chk({nm, "_pc4"}, {32'd0, pc4_out}, 64'h4440);
        chk({nm, "_flags"}, {61'd0, ovf, illegal, zero}, 64'd0);
    endtask

    initial begin
        vecs[0]  = '{"add",        6'b000000, 32'h1234_5678, 32'h956B_A988, 32'h0,         32'hA7A0_0000, 32'h0,     1'b0, 1'b0, 1'b0};
        vecs[1]  = '{"subi",       6'b000011, 32'h0000_000A, 32'h0,         32'hFFFF_FFF5, 32'h0000_0015, 32'h0,     1'b0, 1'b0, 1'b0};
        vecs[2]  = '{"add_ovf",    6'b000000, 32'h7FFF_FFFF, 32'h1,         32'h0,         32'h8000_0000, 32'h0,     1'b0, 1'b1, 1'b0};
        vecs[3]  = '{"xor",        6'b001010, 32'h0000_000A, 32'hF0,        32'h0,         32'h0000_00FA, 32'h0,     1'b0, 1'b0, 1'b0};
        vecs[4]  = '{"ldw",        6'b001100, 32'h0000_0100, 32'h55,        32'h8,         32'h0000_0055, 32'h108,   1'b0, 1'b0, 1'b0};
        vecs[5]  = '{"illegal3f",  6'b111111, 32'h1111_1111, 32'h2222,      32'h3,         32'h0,         32'h0,     1'b1, 1'b0, 1'b1};
        vecs[6]  = '{"sub_zero",   6'b000010, 32'h0000_0005, 32'h5,         32'h0,         32'h0,         32'h0,     1'b1, 1'b0, 1'b0};
        vecs[7]  = '{"sub_ovf",    6'b000010, 32'h8000_0000, 32'h1,         32'h0,         32'h7FFF_FFFF, 32'h0,     1'b0, 1'b1, 1'b0};
        vecs[8]  = '{"ori",        6'b000111, 32'h0000_00F0, 32'hFFFF,      32'h0F,        32'h0000_00FF, 32'h0,     1'b0, 1'b0, 1'b0};
        vecs[9]  = '{"and",        6'b001000, 32'h0000_FF00, 32'h0FF0,      32'h0,         32'h0000_0F00, 32'h0,     1'b0, 1'b0, 1'b0};
        vecs[10] = '{"stw",        6'b001101, 32'h0000_0200, 32'hDEAD,      32'hFFFF_FFFC, 32'h0000_DEAD, 32'h1FC,   1'b0, 1'b0, 1'b0};
        vecs[11] = '{"addi_neg",   6'b000001, 32'h0000_0005, 32'h999,       32'hFFFF_FFFF, 32'h0000_0004, 32'h0,     1'b0, 1'b0, 1'b0};
        vecs[12] = '{"illegal0e",  6'b001110, 32'h0000_0007, 32'h7,         32'h7,         32'h0,         32'h0,     1'b1, 1'b0, 1'b1};

        // Reset state.
        #12;
        chk("reset_outputs", {out_valid, zero, ovf, illegal, rd, addr, pc4_out}, '0);
        chk("reset_in_ready", {63'd0, in_ready}, 64'd1);
        @(negedge clk);
        rst_n = 1'b1;

        // Table: streamed back-to-back with out_ready high, each result one cycle after accept.
        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            drive(vecs[i].op, vecs[i].rs, vecs[i].rt, vecs[i].imm, 32'h1000 + 32'(i * 4));
            @(posedge clk); #1;
            in_valid = 1'b0;
            chk({vecs[i].name, "_valid"}, {63'd0, out_valid}, 64'd1);
            chk({vecs[i].name, "_rd"}, {32'd0, rd}, {32'd0, vecs[i].e_rd});
            chk({vecs[i].name, "_addr"}, {32'd0, addr}, {32'd0, vecs[i].e_addr});
            chk({vecs[i].name, "_pc4"}, {32'd0, pc4_out}, 64'(32'h1000 + 32'(i * 4)));
            chk({vecs[i].name, "_flags"}, {61'd0, zero, ovf, illegal},
                {61'd0, vecs[i].e_zero, vecs[i].e_ovf, vecs[i].e_ill});
        end

        // Multiplies.
        run_mul("mul", 6'b000100, 32'h100, 32'h8, 32'h0, 32'h800);
        run_mul("muli", 6'b000101, 32'hFFFF_FFFF, 32'h0, 32'h2, 32'hFFFF_FFFE);

        // Back-pressure: drain to IDLE, accept an ADD, then stall with a SUB pending.
        @(negedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        drive(6'b000000, 32'h1, 32'h2, 32'h0, 32'h2000);
        @(posedge clk); #1;
        drive(6'b000010, 32'h9, 32'h4, 32'h0, 32'h2004);
        begin
            int bad;
            bad = 0;
            for (int c = 0; c < 5; c++) begin
                if (!out_valid || rd !== 32'h3 || pc4_out !== 32'h2000 || in_ready) bad++;
                @(posedge clk); #1;
            end
            chk("bp_stable", 64'(bad), 64'd0);
        end
        @(negedge clk);
        out_ready = 1'b1;
        #1 chk("bp_release_in_ready", {63'd0, in_ready}, 64'd1);
        @(posedge clk); #1;
        chk("bp_sub_rd", {32'd0, rd}, 64'h5);
        chk("bp_sub_pc4", {32'd0, pc4_out}, 64'h2004);
        drive(6'b000110, 32'h10, 32'h01, 32'h0, 32'h2008);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("bp_stream_or", {31'd0, out_valid, rd}, {31'd0, 1'b1, 32'h11});

        // Reset 10 cycles into a multiply, then a fresh ADD right at release.
        @(negedge clk);
        drive(6'b000100, 32'h100, 32'h8, 32'h0, 32'h3000);
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_mul_outputs", {out_valid, zero, ovf, illegal, rd, addr, pc4_out}, '0);
        chk("rst_mid_mul_in_ready", {63'd0, in_ready}, 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        drive(6'b000000, 32'h3, 32'h4, 32'h0, 32'h3004);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("post_rst_add", {29'd0, out_valid, ovf, illegal, rd}, {29'd0, 1'b1, 1'b0, 1'b0, 32'h7});
        begin
            int stale;
            stale = 0;
            for (int c = 0; c < 40; c++) begin
                @(posedge clk); #1;
                if (out_valid || rd !== 32'h7) stale++;
            end
            chk("no_stale_product", 64'(stale), 64'd0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
